mux2_rr_arbiter: RTL
====================

Name: mux2_rr_arbiter

Overview:
- Shares the 32-bit 2:1 datapath mux (Sel/A/B/C) between two independent requesters, each with a valid/ready handshake.
- Selects one requester per transfer using round-robin and drives Sel for the internal Mux2to1 instance.
- Registers the mux output C into a single-entry output buffer that downstream logic consumes through a valid/ready handshake.
- Sits between two producer stages and one consumer stage of the processor datapath.

Parameters:
- WIDTH, 32, data width of A, B and C; the Mux2to1 instance is 32-bit, so only 32 is legal.
- INIT_LAST, 1, value of the last-grant pointer after reset (1 = B granted last, so A wins the first tie).

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- ValidA  input  1  requester A presents data.
- A  input  WIDTH  requester A data.
- ReadyA  output  1  A transfer occurs when ValidA && ReadyA.
- ValidB  input  1  requester B presents data.
- B  input  WIDTH  requester B data.
- ReadyB  output  1  B transfer occurs when ValidB && ReadyB.
- ValidC  output  1  output buffer holds data.
- C  output  WIDTH  registered mux output.
- ReadyC  input  1  consumer accepts; transfer occurs when ValidC && ReadyC.
- Sel  output  1  combinational mux select for this cycle (0 = A, 1 = B); also drives the internal Mux2to1.
- SrcC  output  1  source of the buffered word (0 = A, 1 = B).

Behaviour:
- Decided interface rule: one clock, Clk; reset Reset is synchronous and active-high. No asynchronous reset anywhere.
- States:
  - EMPTY: buffer empty, ValidC=0.
  - FULL: buffer holds one word, ValidC=1.
- Reset values (Reset=1 at a rising edge): state EMPTY, ValidC=0, C=0, SrcC=0, Last=INIT_LAST. During Reset, ReadyA=ReadyB=0.
- Space: space = (state==EMPTY) || ReadyC. The buffer accepts a new word in the same cycle it is drained.
- Grant, combinational:
  - Only ValidA: grant A.
  - Only ValidB: grant B.
  - Both valid: grant !Last.
  - Neither valid: no grant; Sel holds the Last value.
- Ready and Sel:
  - ReadyA = space && grant==A && !Reset.
  - ReadyB = space && grant==B && !Reset.
  - Sel = granted source.
  - Ready never depends on the requester's own Valid except through the grant decision. ReadyX is 0 whenever ValidX is 0.
- On a transfer:
  - C <= mux output (A when Sel=0, B when Sel=1).
  - SrcC <= Sel, Last <= Sel, state <= FULL.
- Drain with no new transfer: state <= EMPTY. C and SrcC keep their stale values.
- Latency: a word is presented on C with ValidC=1 one cycle after its handshake.
- Throughput: one word per cycle when ReadyC stays 1.
- Fairness: with both requesters valid continuously, grants alternate A,B,A,B,… and neither is starved for more than one transfer.
- Backpressure: while FULL and ReadyC=0:
  - ReadyA=ReadyB=0.
  - C, SrcC and ValidC are held stable.
  - Last does not change.
- Simultaneous events:
  - Drain plus new grant in the same cycle: the buffer is replaced and state stays FULL.
  - Requester valids dropping without a handshake have no effect.
- Reset mid-operation: buffered data is discarded; state returns to EMPTY and Last to INIT_LAST on the next edge.

Optional Feature:
- Macro: MUX2_ARB_FIXED_PRI_EN.
- Defined: fixed priority, A always wins when both are valid. Last is still updated but is ignored for arbitration, so B may starve.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset check: Reset=1 for 2 cycles with ValidA=ValidB=1 -> ValidC=0, C=0, ReadyA=ReadyB=0. On the first cycle after Reset falls, ReadyA=1 (INIT_LAST=1).
- A only: A=29, ValidA=1, ReadyC=1 -> handshake cycle has Sel=0. Next cycle C=29, ValidC=1, SrcC=0.
- Both valid continuously: A=29, B=13, ReadyC=1 for 6 cycles -> C sequence 29,13,29,13,29,13 with SrcC toggling.
  - With MUX2_ARB_FIXED_PRI_EN defined -> C=29 every cycle.
- Backpressure: buffer FULL with C=13, ReadyC=0 for 3 cycles, ValidA=1 -> ReadyA=0 and C=13 held. Raise ReadyC -> same-cycle ReadyA=1; next cycle C=29.
- Reset mid-operation: FULL with C=13 and ReadyC=0, assert Reset one cycle -> ValidC=0, C=0. Next grant with both valid goes to A.
- Idle hold: ValidA=ValidB=0 after a B grant -> Sel stays 1, ValidC drops after one drain, and C retains 13.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin share of a 32-bit 2:1 mux between two valid/ready requesters
// Optional macro MUX2_ARB_FIXED_PRI_EN: A always wins ties (Last still tracked, ignored for arbitration).

module mux2to1 (
   input  logic        sel,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] c
);
   assign c = sel ? b : a;
endmodule

module mux2_rr_arbiter #(
   parameter int WIDTH     = 32,
   parameter bit INIT_LAST = 1'b1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             ValidA,
   input  logic [WIDTH-1:0] A,
   output logic             ReadyA,
   input  logic             ValidB,
   input  logic [WIDTH-1:0] B,
   output logic             ReadyB,
   output logic             ValidC,
   output logic [WIDTH-1:0] C,
   input  logic             ReadyC,
   output logic             Sel,
   output logic             SrcC
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic             src_q, src_d;
   logic             last_q, last_d;

   logic             space;
   logic             any_valid;
   logic             grant_b;
   logic             xfer;
   logic [WIDTH-1:0] mux_out;

   mux2to1 u_mux (
      .sel (Sel),
      .a   (A),
      .b   (B),
      .c   (mux_out)
   );

   // B wins only when it is alone, or on a tie when A was granted last.
   always_comb begin
      any_valid = ValidA | ValidB;
`ifdef MUX2_ARB_FIXED_PRI_EN
      grant_b   = ValidB & ~ValidA;
`else
      grant_b   = ValidB & (~ValidA | ~last_q);
`endif
      Sel       = any_valid ? grant_b : last_q;
      space     = (state_q == EMPTY) | ReadyC;
      ReadyA    = space & ValidA & ~grant_b & ~Reset;
      ReadyB    = space & ValidB &  grant_b & ~Reset;
      xfer      = (ValidA & ReadyA) | (ValidB & ReadyB);
   end

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      src_d   = src_q;
      last_d  = last_q;
      if (xfer) begin
         state_d = FULL;
         c_d     = mux_out;
         src_d   = Sel;
         last_d  = Sel;
      end else if (state_q == FULL && ReadyC) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= EMPTY;
         c_q     <= '0;
         src_q   <= 1'b0;
         last_q  <= INIT_LAST;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         src_q   <= src_d;
         last_q  <= last_d;
      end
   end

   assign ValidC = (state_q == FULL);
   assign C      = c_q;
   assign SrcC   = src_q;

endmodule
